// File: rtl/tetris_piece_scheduler.sv
// Active-block sequencer for the Tetris VGA display: spawn, gravity, player moves, landing and lock delay.
// Position only moves on the frame tick, so the pixel compositor never sees a change mid-frame.
module tetris_piece_scheduler #(
  parameter int PLAYAREA_START = 200,
  parameter int PLAYAREA_END   = 440,
  parameter int SCREEN_H       = 480,
  parameter int BLOCK_W        = 48,
  parameter int BLOCK_H        = 48,
  parameter int STEP_X         = 24,
  parameter int SPAWN_X        = 296,
  parameter int GRAVITY_FRAMES = 2,
  parameter int SOFT_STEP      = 8,
  parameter int LOCK_FRAMES    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       start,
  input  logic       left,
  input  logic       right,
  input  logic       down,
  input  logic       up,
  output logic [9:0] block_x,
  output logic [8:0] block_y,
  output logic [1:0] state,
  output logic       landed
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_FALL  = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  localparam int GW = $clog2(GRAVITY_FRAMES + 1);
  localparam int LW = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0]   LEFT_MIN  = 11'(PLAYAREA_START + STEP_X);
  localparam logic [10:0]   RIGHT_LIM = 11'(PLAYAREA_END);
  localparam logic [10:0]   W_STEP    = 11'(BLOCK_W + STEP_X);
  localparam logic [9:0]    SPAWN_X10 = 10'(SPAWN_X);
  localparam logic [9:0]    STEP_X10  = 10'(STEP_X);
  localparam logic [8:0]    FLOOR     = 9'(SCREEN_H - BLOCK_H);
  localparam logic [8:0]    SOFT_LIM  = 9'(SCREEN_H - BLOCK_H - SOFT_STEP);
  localparam logic [8:0]    SOFT9     = 9'(SOFT_STEP);
  localparam logic [GW-1:0] GRAV_ONE  = GW'(1);
  localparam logic [GW-1:0] GRAV_N    = GW'(GRAVITY_FRAMES);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);
  localparam logic [LW-1:0] LOCK_N    = LW'(LOCK_FRAMES);

  logic [5:0]    sync1_r, sync2_r;
  logic          fe_prev_r, tick_r, start_s;
  logic [3:0]    btn_prev_r, btn_rise_s, pend_r, pend_nxt;
  state_t        state_r, state_nxt;
  logic [9:0]    block_x_r, x_nxt, x_mov_s;
  logic [8:0]    block_y_r, y_nxt, y_fall_s;
  logic [GW-1:0] grav_r, grav_nxt, grav_inc_s, grav_fall_s;
  logic [LW-1:0] lock_r, lock_nxt, lock_inc_s;
  logic          landed_r, landed_nxt, lock_done_s, at_floor_s, mv_left_s, mv_right_s;

  // Two-flop synchronizers plus edge history; tick lands 3 clk after a frame_end rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r    <= 6'd0;
      sync2_r    <= 6'd0;
      fe_prev_r  <= 1'b0;
      btn_prev_r <= 4'd0;
      tick_r     <= 1'b0;
    end else begin
      sync1_r    <= {up, down, right, left, start, frame_end};
      sync2_r    <= sync1_r;
      fe_prev_r  <= sync2_r[0];
      btn_prev_r <= sync2_r[5:2];
      tick_r     <= sync2_r[0] & ~fe_prev_r;
    end
  end

  assign start_s    = sync2_r[1];
  assign btn_rise_s = sync2_r[5:2] & ~btn_prev_r;

  // Horizontal candidate: opposing requests cancel, out-of-range requests are dropped.
  always_comb begin
    mv_left_s  = pend_r[0] & ~pend_r[1];
    mv_right_s = pend_r[1] & ~pend_r[0];
    if (mv_left_s && ({1'b0, block_x_r} >= LEFT_MIN)) begin
      x_mov_s = block_x_r - STEP_X10;
    end else if (mv_right_s && (({1'b0, block_x_r} + W_STEP) <= RIGHT_LIM)) begin
      x_mov_s = block_x_r + STEP_X10;
    end else begin
      x_mov_s = block_x_r;
    end
  end

  // Vertical candidate and lock counting; hard drop beats soft drop beats gravity.
  always_comb begin
    grav_inc_s  = grav_r + GRAV_ONE;
    lock_inc_s  = lock_r + LOCK_ONE;
    lock_done_s = (lock_inc_s == LOCK_N);
    grav_fall_s = grav_r;
    if (pend_r[3]) begin
      y_fall_s = FLOOR;
    end else if (pend_r[2]) begin
      if (block_y_r >= SOFT_LIM) y_fall_s = FLOOR;
      else                       y_fall_s = block_y_r + SOFT9;
    end else if (grav_inc_s == GRAV_N) begin
      grav_fall_s = {GW{1'b0}};
      if (block_y_r >= FLOOR) y_fall_s = FLOOR;
      else                    y_fall_s = block_y_r + 9'd1;
    end else begin
      grav_fall_s = grav_inc_s;
      y_fall_s    = block_y_r;
    end
    at_floor_s = (y_fall_s == FLOOR);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt;
  end

  // Next-state logic; dropping start always wins over a landing.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt = ST_SPAWN;
        else         state_nxt = ST_IDLE;
      end
      ST_SPAWN: state_nxt = ST_FALL;
      ST_FALL: begin
        if (!start_s)                 state_nxt = ST_IDLE;
        else if (tick_r && at_floor_s) state_nxt = ST_LOCK;
        else                          state_nxt = ST_FALL;
      end
      ST_LOCK: begin
        if (!start_s)                  state_nxt = ST_IDLE;
        else if (tick_r && lock_done_s) state_nxt = ST_SPAWN;
        else                           state_nxt = ST_LOCK;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath next values; pending flags consumed on a tick keep any edge arriving with it.
  always_comb begin
    x_nxt      = block_x_r;
    y_nxt      = block_y_r;
    grav_nxt   = grav_r;
    lock_nxt   = lock_r;
    landed_nxt = 1'b0;
    pend_nxt   = pend_r | btn_rise_s;
    case (state_r)
      ST_IDLE: begin
        x_nxt    = SPAWN_X10;
        y_nxt    = 9'd0;
        pend_nxt = 4'd0;
      end
      ST_SPAWN: begin
        x_nxt    = SPAWN_X10;
        y_nxt    = 9'd0;
        grav_nxt = {GW{1'b0}};
        lock_nxt = {LW{1'b0}};
      end
      ST_FALL: begin
        if (!start_s) begin
          x_nxt    = SPAWN_X10;
          y_nxt    = 9'd0;
          pend_nxt = 4'd0;
        end else if (tick_r) begin
          x_nxt    = x_mov_s;
          y_nxt    = y_fall_s;
          grav_nxt = grav_fall_s;
          lock_nxt = {LW{1'b0}};
          pend_nxt = btn_rise_s;
        end else begin
          pend_nxt = pend_r | btn_rise_s;
        end
      end
      ST_LOCK: begin
        if (!start_s) begin
          x_nxt    = SPAWN_X10;
          y_nxt    = 9'd0;
          pend_nxt = 4'd0;
        end else if (tick_r) begin
          x_nxt      = x_mov_s;
          lock_nxt   = lock_inc_s;
          landed_nxt = lock_done_s;
          pend_nxt   = btn_rise_s;
        end else begin
          pend_nxt = pend_r | btn_rise_s;
        end
      end
      default: begin
        x_nxt    = SPAWN_X10;
        y_nxt    = 9'd0;
        pend_nxt = 4'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_x_r <= SPAWN_X10;
      block_y_r <= 9'd0;
      grav_r    <= {GW{1'b0}};
      lock_r    <= {LW{1'b0}};
      landed_r  <= 1'b0;
      pend_r    <= 4'd0;
    end else begin
      block_x_r <= x_nxt;
      block_y_r <= y_nxt;
      grav_r    <= grav_nxt;
      lock_r    <= lock_nxt;
      landed_r  <= landed_nxt;
      pend_r    <= pend_nxt;
    end
  end

  assign block_x = block_x_r;
  assign block_y = block_y_r;
  assign state   = state_r;
  assign landed  = landed_r;
endmodule
